rmw_cmd_scheduler: RTL
======================

// Module: rmw_cmd_scheduler
// PURPOSE
//   Shares one single-port memory and one add/sub unit among NUM_REQ requesters.
//   Round-robin arbitration; each granted command runs to completion (READ, WRITE, ADD, SUB).
//   ADD/SUB are read-modify-write: mem[addr] = mem[addr] +/- operand.
//   Sits between the requester ports and the memory macro; only master of the mem_* bus.
// PARAMETERS
//   NUM_REQ  4   number of requesters (>=2)
//   ADDR_W   8   memory address width
//   DATA_W   16  data / operand width
// PORTS
//   clk        in   1                  clock, rising edge
//   rst_n      in   1                  asynchronous reset, active low
//   req_valid  in   NUM_REQ            per-requester command valid
//   req_ready  out  NUM_REQ            one-hot grant; transfer when valid & ready
//   req_op     in   2*NUM_REQ          op per requester: 00 READ, 01 WRITE, 10 ADD, 11 SUB
//   req_addr   in   ADDR_W*NUM_REQ     address per requester
//   req_data   in   DATA_W*NUM_REQ     write data / operand per requester
//   rsp_valid  out  1                  one-cycle completion pulse; no backpressure
//   rsp_id     out  $clog2(NUM_REQ)    index of the completing requester
//   rsp_data   out  DATA_W             READ: read data; ADD/SUB: result; WRITE: written data
//   rsp_flag   out  1                  ADD: carry out; SUB: borrow; READ/WRITE: 0
//   mem_en     out  1                  memory access strobe
//   mem_we     out  1                  write enable, qualified by mem_en
//   mem_addr   out  ADDR_W             memory address
//   mem_wdata  out  DATA_W             memory write data
//   mem_rdata  in   DATA_W             read data, valid 1 cycle after mem_en & !mem_we
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; rr pointer=NUM_REQ-1 (requester 0 wins first).
//     All outputs 0. Takes effect mid-command: access abandoned, no rsp_valid.
//   FSM states: IDLE, RUN, WAIT, EXEC, DONE.
//   IDLE
//     req_ready = combinational one-hot grant, searching from pointer+1 with wrap.
//     Grant only when some req_valid=1. On grant: latch op/addr/data/id, pointer=id -> RUN.
//   RUN
//     mem_en=1, mem_addr=addr; mem_we=1 only for WRITE (mem_wdata=data).
//     WRITE -> DONE; others -> WAIT.
//   WAIT
//     Capture mem_rdata. READ -> DONE; ADD/SUB -> EXEC.
//   EXEC
//     result = rdata + data (ADD) or rdata - data (SUB), modulo 2^DATA_W.
//     Flag = carry out (ADD) or borrow, i.e. rdata < data unsigned (SUB).
//     mem_en=1, mem_we=1, mem_wdata=result -> DONE.
//   DONE
//     rsp_valid=1 for exactly one cycle with rsp_id/rsp_data/rsp_flag -> IDLE.
//     rsp_* hold their last value otherwise.
//   Latency, accept cycle to rsp_valid: WRITE 2, READ 3, ADD/SUB 4 cycles.
//     One command in flight; req_ready all 0 outside IDLE.
//   req_valid may drop before grant; no request is remembered.
//     Valid requests are never starved: at most NUM_REQ-1 other grants first.
//   Addresses of back-to-back commands may match; the second sees the first's write.
// CONFIGURATION
//   RMW_SCHED_PRIO_EN defined: requester 0 has strict priority.
//     If req_valid[0]=1 in IDLE it wins; the rr pointer is not updated by its grant.
//     Others are round-robin among themselves.
//   Not defined: pure round-robin across all requesters.
// STRUCTURE
//   rmw_sched_pkg: op encoding typedef (OP_READ/OP_WRITE/OP_ADD/OP_SUB).
//     Also the FSM state typedef and the rsp_flag semantics constants.
//   Sub-module rr_arbiter: NUM_REQ-wide one-hot round-robin grant.
//     Inputs: pointer and request vector. Output: grant. Combinational.
//   FSM, operand registers and ALU stay in rmw_cmd_scheduler.
// TESTING
//   WRITE req1 addr 0x10 data 0x1234, then READ req1 addr 0x10
//     -> mem write seen; rsp_data=0x1234, flag=0, latencies 2 and 3.
//   mem[0x20]=0xFFFF, ADD req2 addr 0x20 data 0x0001
//     -> rsp_data=0x0000, flag=1; mem[0x20]=0x0000 after 4 cycles.
//   mem[0x30]=0x0003, SUB req0 data 0x0005
//     -> rsp_data=0xFFFE, flag=1; then SUB data 0x0001 -> 0xFFFD, flag=0.
//   All 4 req_valid held high continuously -> grants 0,1,2,3,0,1 in order, one rsp each.
//   RMW_SCHED_PRIO_EN: req0 and req2 always valid -> req0 every grant.
//     Without the macro -> alternating 0,2,0,2.
//   rst_n low during EXEC of an ADD
//     -> no mem write, no rsp_valid; outputs 0.
//     After release, next grant goes to requester 0.

Source files
------------

// File: rtl/rmw_sched_pkg.sv
// Shared types for the read-modify-write command scheduler.
//   op_e    : command encoding carried on req_op
//   state_e : scheduler FSM state encoding
//   FLAG_*  : rsp_flag meaning per command
package rmw_sched_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_ADD   = 2'b10,
      OP_SUB   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_WAIT = 3'd2,
      ST_EXEC = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // READ and WRITE always report FLAG_NONE; ADD reports carry-out and SUB
   // reports borrow (FLAG_SET when the stored value is below the operand).
   localparam logic FLAG_NONE = 1'b0;
   localparam logic FLAG_SET  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin grant, purely combinational.
//   ptr_i   : index of the most recently granted requester
//   req_i   : request vector
//   grant_o : one-hot grant, search starts at ptr_i+1 and wraps; 0 if no request
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [ID_W-1:0]    ptr_i,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] grant_o
);

   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic found;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         int idx;
         idx = (int'(ptr_i) + i) % NUM_REQ;
         if (!found && (((req_i >> idx) & ONE) != '0)) begin
            grant_o = ONE << idx;
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rmw_cmd_scheduler.sv
// Shares one single-port memory and one add/sub unit among NUM_REQ requesters.
// Round-robin arbitration, one command in flight; ADD/SUB are read-modify-write.
// Optional build macro: RMW_SCHED_PRIO_EN gives requester 0 strict priority
// (its grants leave the round-robin pointer untouched).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                per-requester handshake, ready is one-hot
//   req_op/req_addr/req_data           packed per-requester command fields
//   rsp_valid/rsp_id/rsp_data/rsp_flag one-cycle completion report
//   mem_en/mem_we/mem_addr/mem_wdata   memory macro command
//   mem_rdata                          memory read data, one cycle after a read
//
// state | meaning
// IDLE  | offer grant, latch winning command
// RUN   | first memory access (read, or the write of a WRITE)
// WAIT  | capture read data
// EXEC  | write back ADD/SUB result
// DONE  | rsp_valid pulse
module rmw_cmd_scheduler
   import rmw_sched_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   parameter int  ADDR_W  = 8,
   parameter int  DATA_W  = 16,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [2*NUM_REQ-1:0]        req_op,
   input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
   input  logic [DATA_W*NUM_REQ-1:0]   req_data,
   output logic                        rsp_valid,
   output logic [ID_W-1:0]             rsp_id,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        rsp_flag,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata
);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, id_q, rsp_id_q, rsp_id_d, grant_id;
   op_e                 op_q;
   logic [ADDR_W-1:0]   addr_q, sel_addr;
   logic [DATA_W-1:0]   data_q, rdata_q, rsp_data_q, rsp_data_d, sel_data, alu_res;
   logic                rsp_flag_q, rsp_flag_d, alu_flag, upd_ptr;
   logic [1:0]          sel_op;
   logic [NUM_REQ-1:0]  arb_req, arb_grant, grant;
   logic [DATA_W:0]     sum_w, diff_w;

`ifdef RMW_SCHED_PRIO_EN
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
   // Requester 0 bypasses the arbiter; the rest rotate among themselves.
   assign arb_req = req_valid & ~ONE;
   assign grant   = req_valid[0] ? ONE : arb_grant;
   assign upd_ptr = ~req_valid[0];
`else
   assign arb_req = req_valid;
   assign grant   = arb_grant;
   assign upd_ptr = 1'b1;
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .ptr_i   (ptr_q),
      .req_i   (arb_req),
      .grant_o (arb_grant)
   );

   always_comb begin
      grant_id = '0;
      sel_op   = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_id = ID_W'(i);
            sel_op   = req_op[2*i +: 2];
            sel_addr = req_addr[ADDR_W*i +: ADDR_W];
            sel_data = req_data[DATA_W*i +: DATA_W];
         end
      end
   end

   // Zero-extended add/sub: the extra MSB is carry for ADD and borrow for SUB.
   assign sum_w    = {1'b0, rdata_q} + {1'b0, data_q};
   assign diff_w   = {1'b0, rdata_q} - {1'b0, data_q};
   assign alu_res  = (op_q == OP_SUB) ? diff_w[DATA_W-1:0] : sum_w[DATA_W-1:0];
   assign alu_flag = (op_q == OP_SUB) ? diff_w[DATA_W] : sum_w[DATA_W];

   assign mem_addr  = addr_q;
   assign mem_wdata = (state_q == ST_EXEC) ? alu_res : data_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flag  = rsp_flag_q;

   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      rsp_valid  = 1'b0;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      rsp_flag_d = rsp_flag_q;
      case (state_q)
         ST_IDLE: begin
            req_ready = grant;
            if (|grant) state_d = ST_RUN;
         end
         ST_RUN: begin
            mem_en = 1'b1;
            if (op_q == OP_WRITE) begin
               mem_we     = 1'b1;
               state_d    = ST_DONE;
               rsp_id_d   = id_q;
               rsp_data_d = data_q;
               rsp_flag_d = FLAG_NONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (op_q == OP_READ) begin
               state_d    = ST_DONE;
               rsp_id_d   = id_q;
               rsp_data_d = mem_rdata;
               rsp_flag_d = FLAG_NONE;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            mem_en     = 1'b1;
            mem_we     = 1'b1;
            state_d    = ST_DONE;
            rsp_id_d   = id_q;
            rsp_data_d = alu_res;
            rsp_flag_d = alu_flag;
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= ID_W'(NUM_REQ-1);
         op_q       <= OP_READ;
         addr_q     <= '0;
         data_q     <= '0;
         id_q       <= '0;
         rdata_q    <= '0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
         rsp_flag_q <= FLAG_NONE;
      end else begin
         state_q    <= state_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         rsp_flag_q <= rsp_flag_d;
         if (state_q == ST_IDLE && |grant) begin
            op_q   <= op_e'(sel_op);
            addr_q <= sel_addr;
            data_q <= sel_data;
            id_q   <= grant_id;
            if (upd_ptr) ptr_q <= grant_id;
         end
         if (state_q == ST_WAIT) rdata_q <= mem_rdata;
      end
   end

endmodule
